// File: rtl/dog_subtractor.sv
// Difference-of-Gaussians pixel subtractor: pairs two 8-bit streams
// through independent FIFOs and emits a signed 9-bit a-minus-b result.
module dog_subtractor #(
  parameter int DEPTH   = 16,
  parameter int N_PIXEL = 120000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a_valid,
  input  logic [7:0] a_din,
  output logic       a_ready,
  input  logic       b_valid,
  input  logic [7:0] b_din,
  output logic       b_ready,
  output logic [8:0] dout,
  output logic       valid_out,
  input  logic       rd_en,
  output logic       frame_done,
  output logic       err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(N_PIXEL);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(N_PIXEL - 1);

  logic [1:0] wvalid;
  logic [1:0] full;
  logic [1:0] nempty;
  logic [1:0] push;
  logic [7:0] wdata [2];
  logic [7:0] rdata [2];
  logic       pop;
  logic       hs;
  logic [8:0] diff;

  assign wvalid   = {b_valid, a_valid};
  assign wdata[0] = a_din;
  assign wdata[1] = b_din;

  // Channel 0 buffers stream A, channel 1 buffers stream B.
  for (genvar c = 0; c < 2; c++) begin : g_fifo
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [AW:0]   cnt_q;
    logic [AW:0]   cnt_d;

    assign full[c]   = (cnt_q == FULL);
    assign nempty[c] = (cnt_q != '0);
    assign push[c]   = wvalid[c] & ~full[c];
    assign rdata[c]  = mem_q[rptr_q];

    always_comb begin
      cnt_d = cnt_q;
      if (push[c] && !pop) begin
        cnt_d = cnt_q + (AW+1)'(1);
      end else if (!push[c] && pop) begin
        cnt_d = cnt_q - (AW+1)'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (push[c]) begin
        mem_q[wptr_q] <= wdata[c];
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wptr_q <= '0;
        rptr_q <= '0;
        cnt_q  <= '0;
      end else begin
        if (push[c]) wptr_q <= wptr_q + AW'(1);
        if (pop)     rptr_q <= rptr_q + AW'(1);
        cnt_q <= cnt_d;
      end
    end
  end

  logic          valid_q;
  logic          valid_d;
  logic [8:0]    dout_q;
  logic [8:0]    dout_d;
  logic [CW-1:0] pcnt_q;
  logic [CW-1:0] pcnt_d;
  logic          fd_q;
  logic          fd_d;
  logic          err_q;
  logic          err_d;

  assign pop  = nempty[0] & nempty[1] & (~valid_q | rd_en);
  assign hs   = valid_q & rd_en;
  assign diff = {1'b0, rdata[0]} - {1'b0, rdata[1]};

  always_comb begin
    valid_d = valid_q;
    dout_d  = dout_q;
    pcnt_d  = pcnt_q;
    fd_d    = 1'b0;
    err_d   = err_q | (|(wvalid & full));
    if (pop) begin
      valid_d = 1'b1;
      dout_d  = diff;
    end else if (hs) begin
      valid_d = 1'b0;
    end
    if (hs) begin
      if (pcnt_q == LAST) begin
        pcnt_d = '0;
        fd_d   = 1'b1;
      end else begin
        pcnt_d = pcnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      dout_q  <= '0;
      pcnt_q  <= '0;
      fd_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      dout_q  <= dout_d;
      pcnt_q  <= pcnt_d;
      fd_q    <= fd_d;
      err_q   <= err_d;
    end
  end

  assign a_ready    = ~full[0];
  assign b_ready    = ~full[1];
  assign dout       = dout_q;
  assign valid_out  = valid_q;
  assign frame_done = fd_q;
  assign err        = err_q;

endmodule

// File: tb/tb_dog_subtractor.sv
// Directed testbench for dog_subtractor with hand-computed results.
module tb_dog_subtractor;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_valid = 1'b0;
  logic [7:0] a_din = '0;
  logic       a_ready;
  logic       b_valid = 1'b0;
  logic [7:0] b_din = '0;
  logic       b_ready;
  logic [8:0] dout;
  logic       valid_out;
  logic       rd_en = 1'b0;
  logic       frame_done;
  logic       err;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  dog_subtractor #(.DEPTH(16), .N_PIXEL(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .a_valid(a_valid),
    .a_din(a_din),
    .a_ready(a_ready),
    .b_valid(b_valid),
    .b_din(b_din),
    .b_ready(b_ready),
    .dout(dout),
    .valid_out(valid_out),
    .rd_en(rd_en),
    .frame_done(frame_done),
    .err(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    a_valid = 1'b0;
    b_valid = 1'b0;
    rd_en   = 1'b0;
    rst_n   = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #12;
    tests++;
    if (valid_out !== 1'b0) begin
      fails++;
      $display("FAIL reset_valid got %0b want 0", valid_out);
    end
    tests++;
    if (dout !== 9'h000) begin
      fails++;
      $display("FAIL reset_dout got %h want 000", dout);
    end
    tests++;
    if ({frame_done, err} !== 2'b00) begin
      fails++;
      $display("FAIL reset_flags got %b want 00",
               {frame_done, err});
    end
    tests++;
    if ({a_ready, b_ready} !== 2'b11) begin
      fails++;
      $display("FAIL reset_ready got %b want 11",
               {a_ready, b_ready});
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_single();
    rd_en   = 1'b1;
    a_valid = 1'b1;
    a_din   = 8'd200;
    b_valid = 1'b1;
    b_din   = 8'd50;
    tick();
    a_valid = 1'b0;
    b_valid = 1'b0;
    tests++;
    if (valid_out !== 1'b0) begin
      fails++;
      $display("FAIL single_early got %0b want 0", valid_out);
    end
    tick();
    tests++;
    if (valid_out !== 1'b1 || dout !== 9'h096) begin
      fails++;
      $display("FAIL single_out got v=%0b d=%h want v=1 d=096",
               valid_out, dout);
    end
    tick();
    tests++;
    if (valid_out !== 1'b0) begin
      fails++;
      $display("FAIL single_clear got %0b want 0", valid_out);
    end
  endtask

  task automatic test_extremes();
    logic [7:0] av [3];
    logic [7:0] bv [3];
    logic [8:0] ex [3];
    logic [8:0] got [8];
    int n = 0;
    int first = -1;
    int last = -1;
    av = '{8'd0, 8'd255, 8'd7};
    bv = '{8'd255, 8'd0, 8'd7};
    ex = '{9'h101, 9'h0FF, 9'h000};
    rd_en = 1'b1;
    for (int cyc = 0; cyc < 10; cyc++) begin
      a_valid = (cyc < 3);
      b_valid = (cyc < 3);
      if (cyc < 3) begin
        a_din = av[cyc];
        b_din = bv[cyc];
      end
      tick();
      if (valid_out && n < 8) begin
        got[n] = dout;
        if (first < 0) first = cyc;
        last = cyc;
        n++;
      end
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    tests++;
    if (n !== 3) begin
      fails++;
      $display("FAIL extreme_count got %0d want 3", n);
    end
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (i >= n || got[i] !== ex[i]) begin
        fails++;
        $display("FAIL extreme_val%0d got %h want %h",
                 i, (i < n) ? got[i] : 9'h1FF, ex[i]);
      end
    end
    tests++;
    if (last - first !== 2) begin
      fails++;
      $display("FAIL extreme_rate got span %0d want 2",
               last - first);
    end
  endtask

  task automatic test_skew();
    logic [8:0] got [8];
    int n = 0;
    int early = 0;
    rd_en = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      a_valid = (cyc < 5);
      a_din   = 8'(10 * (cyc + 1));
      b_valid = (cyc >= 15 && cyc < 20);
      b_din   = 8'(cyc - 14);
      tick();
      if (valid_out) begin
        if (cyc <= 15) early++;
        if (n < 8) got[n] = dout;
        n++;
      end
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    tests++;
    if (early !== 0) begin
      fails++;
      $display("FAIL skew_early got %0d want 0", early);
    end
    tests++;
    if (n !== 5) begin
      fails++;
      $display("FAIL skew_count got %0d want 5", n);
    end
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (i >= n || got[i] !== 9'(9 * (i + 1))) begin
        fails++;
        $display("FAIL skew_val%0d got %h want %h",
                 i, (i < n) ? got[i] : 9'h1FF, 9'(9 * (i + 1)));
      end
    end
  endtask

  task automatic test_backpressure();
    logic [8:0] got [32];
    int n = 0;
    int bad = 0;
    rd_en = 1'b0;
    for (int i = 0; i < 17; i++) begin
      a_valid = 1'b1;
      a_din   = 8'(10 * i + 5);
      b_valid = 1'b1;
      b_din   = 8'(i);
      tick();
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    tests++;
    if ({a_ready, b_ready} !== 2'b00) begin
      fails++;
      $display("FAIL bp_ready got %b want 00", {a_ready, b_ready});
    end
    tests++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL bp_err_17 got %0b want 0", err);
    end
    tests++;
    if (valid_out !== 1'b1 || dout !== 9'h005) begin
      fails++;
      $display("FAIL bp_hold got v=%0b d=%h want v=1 d=005",
               valid_out, dout);
    end
    a_valid = 1'b1;
    a_din   = 8'd250;
    tick();
    a_valid = 1'b0;
    tests++;
    if (err !== 1'b1) begin
      fails++;
      $display("FAIL bp_err_18 got %0b want 1", err);
    end
    rd_en = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (valid_out) begin
        if (n < 32) got[n] = dout;
        n++;
      end
      tick();
    end
    tests++;
    if (n !== 17) begin
      fails++;
      $display("FAIL bp_count got %0d want 17", n);
    end
    for (int i = 0; i < 17; i++) begin
      if (i >= n || got[i] !== 9'(9 * i + 5)) bad++;
    end
    tests++;
    if (bad !== 0) begin
      fails++;
      $display("FAIL bp_order got %0d bad entries want 0", bad);
    end
    tests++;
    if ({a_ready, b_ready, err} !== 3'b111) begin
      fails++;
      $display("FAIL bp_after got %b want 111",
               {a_ready, b_ready, err});
    end
  endtask

  task automatic test_frame();
    logic [15:0] marks = '0;
    int n = 0;
    do_reset();
    rd_en = 1'b1;
    for (int cyc = 0; cyc < 15; cyc++) begin
      a_valid = (cyc < 9);
      a_din   = 8'(cyc + 20);
      b_valid = (cyc < 9);
      b_din   = 8'(cyc);
      tick();
      if (frame_done) marks[n] = 1'b1;
      if (valid_out) n++;
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    tests++;
    if (n !== 9) begin
      fails++;
      $display("FAIL frame_count got %0d want 9", n);
    end
    tests++;
    if (marks !== 16'h0110) begin
      fails++;
      $display("FAIL frame_done got %h want 0110", marks);
    end
  endtask

  task automatic test_reset_mid();
    logic [8:0] last = '0;
    int n = 0;
    rd_en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      a_valid = 1'b1;
      a_din   = 8'(100 + i);
      b_valid = 1'b1;
      b_din   = 8'(i);
      tick();
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    tests++;
    if (valid_out !== 1'b1) begin
      fails++;
      $display("FAIL mid_pre got %0b want 1", valid_out);
    end
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if ({valid_out, a_ready, b_ready} !== 3'b011) begin
      fails++;
      $display("FAIL mid_async got %b want 011",
               {valid_out, a_ready, b_ready});
    end
    tests++;
    if (dout !== 9'h000) begin
      fails++;
      $display("FAIL mid_dout got %h want 000", dout);
    end
    tick();
    rst_n = 1'b1;
    rd_en = 1'b1;
    for (int cyc = 0; cyc < 8; cyc++) begin
      a_valid = (cyc == 0);
      a_din   = 8'd9;
      b_valid = (cyc == 0);
      b_din   = 8'd100;
      tick();
      if (valid_out) begin
        last = dout;
        n++;
      end
    end
    a_valid = 1'b0;
    b_valid = 1'b0;
    tests++;
    if (n !== 1 || last !== 9'h1A5) begin
      fails++;
      $display("FAIL mid_new got n=%0d d=%h want n=1 d=1a5",
               n, last);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_extremes();
    test_skew();
    test_backpressure();
    test_frame();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
